// File: rtl/synapse_accumulator_pkg.sv
// Shared definitions for the synapse accumulator: derived sum width, FSM encodings and a
// sign-extension helper.
package synapse_accumulator_pkg;

   // FSM encodings, kept as plain constants for compatibility with older tooling
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAccum = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   // Width of one accumulated sum: enough headroom for np terms of wf bits
   function automatic int unsigned calcWa(input int unsigned np, input int unsigned wf);
      return $clog2(np) + wf;
   endfunction

   // Sign-extend the low 'width' bits of val to 32 bits
   function automatic logic signed [31:0] signExt(input logic [31:0] val,
                                                  input int unsigned width);
      logic signed [31:0] tmp;
      tmp = val << (32 - width);
      return tmp >>> (32 - width);
   endfunction

endpackage

// File: rtl/synapse_weight_ram.sv
// Weight table: NP rows of NC packed signed weights. One synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module synapse_weight_ram #(
   parameter int unsigned NP = 4,
   parameter int unsigned NC = 4,
   parameter int unsigned WF = 4,
   localparam int unsigned AW = $clog2(NP)
) (
   input  logic             iCLK,
   input  logic             iWe,
   input  logic [AW-1:0]    iWrAddr,
   input  logic [NC*WF-1:0] iWrData,
   input  logic [AW-1:0]    iRdAddr,
   output logic [NC*WF-1:0] oRdData
);

   logic [NC*WF-1:0] memQ [NP];

   // Row write; the caller has already qualified the enable and the address range
   always_ff @(posedge iCLK) begin
      if (iWe) begin
         memQ[iWrAddr] <= iWrData;
      end
   end

   assign oRdData = memQ[iRdAddr];

endmodule

// File: rtl/synapse_accumulator.sv
// Serial synapse accumulator: accepts one binary presynaptic state vector, accumulates NC
// signed weighted sums over NP cycles, then presents them as a single valid/ready beat.
module synapse_accumulator
   import synapse_accumulator_pkg::*;
#(
   parameter int unsigned NP = 4,
   parameter int unsigned NC = 4,
   parameter int unsigned WF = 4,
   localparam int unsigned WA = calcWa(NP, WF),
   localparam int unsigned AW = $clog2(NP)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid_BM_State,
   output logic             oReady_BM_State,
   input  logic [NP-1:0]    iData_BM_State,
   input  logic             iWe_Weight,
   input  logic [AW-1:0]    iAddr_Weight,
   input  logic [NC*WF-1:0] iData_Weight,
   output logic             oValid_AS_Accum0,
   input  logic             iReady_AS_Accum0,
   output logic [NC*WA-1:0] oData_AS_Accum0
);

   logic [1:0]           stateQ, stateD;
   logic [AW-1:0]        cntQ, cntD;
   logic [NP-1:0]        vecQ, vecD;
   logic signed [WA-1:0] accQ [NC];
   logic signed [WA-1:0] accD [NC];
   logic [NC*WA-1:0]     dataQ, dataD;
   logic                 validQ, validD;
   logic                 readyQ, readyD;
   logic [NC*WF-1:0]     rdRow;
   logic                 accept;
   logic                 weWrite;
   logic                 lastTerm;

   // readyQ is only ever set while in IDLE, so it alone qualifies the handshake
   assign accept   = iValid_BM_State & readyQ;
   assign weWrite  = iWe_Weight & (stateQ == StIdle) & (32'(iAddr_Weight) < NP);
   assign lastTerm = (cntQ == AW'(NP - 1));

   synapse_weight_ram #(
      .NP (NP),
      .NC (NC),
      .WF (WF)
   ) uWeightRam (
      .iCLK    (iCLK),
      .iWe     (weWrite),
      .iWrAddr (iAddr_Weight),
      .iWrData (iData_Weight),
      .iRdAddr (cntQ),
      .oRdData (rdRow)
   );

   // Next-state: FSM sequencing, serial accumulation and output register load
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      vecD   = vecQ;
      dataD  = dataQ;
      validD = validQ;
      for (int c = 0; c < NC; c++) begin
         accD[c] = accQ[c];
      end

      case (stateQ)
         StIdle: begin
            if (accept) begin
               vecD   = iData_BM_State;
               cntD   = '0;
               stateD = StAccum;
               for (int c = 0; c < NC; c++) begin
                  accD[c] = '0;
               end
            end
         end
         StAccum: begin
            if (vecQ[cntQ]) begin
               for (int c = 0; c < NC; c++) begin
                  accD[c] = accQ[c] + WA'(signExt(32'(rdRow[c*WF +: WF]), WF));
               end
            end
            if (lastTerm) begin
               cntD   = '0;
               stateD = StDone;
            end else begin
               cntD = cntQ + AW'(1);
            end
         end
         StDone: begin
            // First DONE cycle registers the sums; they then hold until accepted
            if (!validQ) begin
               validD = 1'b1;
               for (int c = 0; c < NC; c++) begin
                  dataD[c*WA +: WA] = accQ[c];
               end
            end else if (iReady_AS_Accum0) begin
               validD = 1'b0;
               stateD = StIdle;
            end
         end
         default: begin
            stateD = StIdle;
         end
      endcase

      readyD = (stateD == StIdle);
   end

   // State registers; the weight table lives in the sub-module and is not reset
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         stateQ <= StIdle;
         cntQ   <= '0;
         vecQ   <= '0;
         dataQ  <= '0;
         validQ <= 1'b0;
         readyQ <= 1'b0;
         for (int c = 0; c < NC; c++) begin
            accQ[c] <= '0;
         end
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         vecQ   <= vecD;
         dataQ  <= dataD;
         validQ <= validD;
         readyQ <= readyD;
         for (int c = 0; c < NC; c++) begin
            accQ[c] <= accD[c];
         end
      end
   end

   assign oReady_BM_State  = readyQ;
   assign oValid_AS_Accum0 = validQ;
   assign oData_AS_Accum0  = dataQ;

endmodule
